// File: rtl/risc16_pkg.sv
// rtl/risc16_pkg.sv - shared types and constants for the data-memory arbiter
package risc16_pkg;

  localparam int W_DEF  = 16;
  localparam int AW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CPU  = 2'd1;
  localparam logic [1:0] OWN_HOST = 2'd2;

endpackage

// File: rtl/risc_16bit_arb_pick.sv
// rtl/risc_16bit_arb_pick.sv - CPU-priority winner selection with host anti-starvation streak
module risc_16bit_arb_pick
  import risc16_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic       cpu_req,
  input  logic       host_req,
  input  logic [3:0] streak,
  output logic [1:0] winner,
  output logic [3:0] next_streak
);

  // Contested grants go to the CPU until the streak saturates, then the host gets one.
  always_comb begin
    winner      = OWN_NONE;
    next_streak = streak;
    if (cpu_req && host_req) begin
      if (streak >= 4'(STREAK_MAX)) begin
        winner      = OWN_HOST;
        next_streak = 4'd0;
      end else begin
        winner      = OWN_CPU;
        next_streak = streak + 4'd1;
      end
    end else if (cpu_req) begin
      winner      = OWN_CPU;
      next_streak = 4'd0;
    end else if (host_req) begin
      winner      = OWN_HOST;
      next_streak = 4'd0;
    end
  end

endmodule

// File: rtl/risc_16bit_dmem_arbiter.sv
// rtl/risc_16bit_dmem_arbiter.sv - two-port arbiter for the single-port data memory
module risc_16bit_dmem_arbiter
  import risc16_pkg::*;
#(
  parameter int W          = W_DEF,
  parameter int AW         = AW_DEF,
  parameter int STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [W-1:0]  cpu_wdata,
  output logic          cpu_ack,
  output logic [W-1:0]  cpu_rdata,
  output logic          cpu_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [W-1:0]  host_wdata,
  output logic          host_ack,
  output logic [W-1:0]  host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [W-1:0]  mem_wdata,
  input  logic [W-1:0]  mem_rdata,
  output logic [1:0]    owner
);

  state_t       state, state_nxt;
  logic [3:0]   streak;
  logic [3:0]   pick_streak;
  logic [1:0]   pick_winner;
  logic         rd_q;
  logic [W-1:0] cpu_rdata_q;
  logic [W-1:0] host_rdata_q;

  risc_16bit_arb_pick #(.STREAK_MAX(STREAK_MAX)) u_pick (
    .cpu_req     (cpu_req),
    .host_req    (host_req),
    .streak      (streak),
    .winner      (pick_winner),
    .next_streak (pick_streak)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: grant on any request, then one strobe cycle, then one ack cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cpu_req || host_req) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Grant latching, memory strobes, acks and read-data holding registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner        <= OWN_NONE;
      streak       <= 4'd0;
      rd_q         <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      cpu_ack      <= 1'b0;
      host_ack     <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      mem_rd   <= 1'b0;
      mem_wr   <= 1'b0;
      cpu_ack  <= 1'b0;
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || host_req) begin
            owner  <= pick_winner;
            streak <= pick_streak;
            if (pick_winner == OWN_CPU) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              mem_wr    <= cpu_we;
              mem_rd    <= ~cpu_we;
              rd_q      <= ~cpu_we;
            end else begin
              mem_addr  <= host_addr;
              mem_wdata <= host_wdata;
              mem_wr    <= host_we;
              mem_rd    <= ~host_we;
              rd_q      <= ~host_we;
            end
          end
        end
        ST_ISSUE: begin
          cpu_ack  <= (owner == OWN_CPU);
          host_ack <= (owner == OWN_HOST);
        end
        ST_DONE: begin
          owner <= OWN_NONE;
          if (rd_q && owner == OWN_CPU)  cpu_rdata_q  <= mem_rdata;
          if (rd_q && owner == OWN_HOST) host_rdata_q <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Memory data arrives during the ack cycle, so it is forwarded straight through
  // while the read ack is high and held in the register afterwards.
  assign cpu_rdata  = (cpu_ack && rd_q)  ? mem_rdata : cpu_rdata_q;
  assign host_rdata = (host_ack && rd_q) ? mem_rdata : host_rdata_q;
  assign cpu_stall  = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_risc_16bit_dmem_arbiter.sv
// tb/tb_risc_16bit_dmem_arbiter.sv - directed self-checking bench for the data-memory arbiter
module tb_risc_16bit_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_wdata, cpu_rdata;
  logic        host_req, host_we, host_ack;
  logic [7:0]  host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic [7:0]  mem_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [1:0]  owner;

  logic [15:0] mem [256];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  risc_16bit_dmem_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .owner      (owner)
  );

  // Synchronous single-port memory: read data valid the cycle after mem_rd.
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else begin
      if (mem_wr) mem[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    preload(8'h12, 16'h1234);
    preload(8'h05, 16'h0001);
    preload(8'h03, 16'h0033);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03; cpu_wdata = 16'h0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40; host_wdata = 16'h0;
    tick(); tick(); tick();
    total++;
    if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== 26'd0) begin
      bad++; $display("FAIL reset_mem got=%h exp=0", {mem_rd, mem_wr, mem_addr, mem_wdata});
    end
    total++;
    if ({cpu_ack, host_ack, cpu_rdata, host_rdata, owner} !== 36'd0) begin
      bad++; $display("FAIL reset_out got=%h exp=0", {cpu_ack, host_ack, cpu_rdata, host_rdata, owner});
    end
    reset = 1'b1;
    tick();
    total++;
    if ({owner, mem_rd, mem_wr, mem_addr} !== {2'd1, 1'b1, 1'b0, 8'h03}) begin
      bad++; $display("FAIL reset_first_grant got=%h exp=%h", {owner, mem_rd, mem_wr, mem_addr}, {2'd1, 1'b1, 1'b0, 8'h03});
    end
    tick();
    total++;
    if ({cpu_ack, host_ack, cpu_rdata} !== {1'b1, 1'b0, 16'h0033}) begin
      bad++; $display("FAIL reset_first_ack got=%h exp=%h", {cpu_ack, host_ack, cpu_rdata}, {1'b1, 1'b0, 16'h0033});
    end
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    #1;
    total++;
    if (cpu_stall !== 1'b1) begin bad++; $display("FAIL cpu_rd_stall_k got=%b exp=1", cpu_stall); end
    tick();
    cpu_addr = 8'h99;
    total++;
    if ({mem_rd, mem_wr, mem_addr, owner, cpu_stall, cpu_ack} !== {1'b1, 1'b0, 8'h12, 2'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL cpu_rd_issue got=%h exp=%h", {mem_rd, mem_wr, mem_addr, owner, cpu_stall, cpu_ack},
                      {1'b1, 1'b0, 8'h12, 2'd1, 1'b1, 1'b0});
    end
    tick();
    total++;
    if ({cpu_ack, cpu_rdata, cpu_stall, mem_rd} !== {1'b1, 16'h1234, 1'b0, 1'b0}) begin
      bad++; $display("FAIL cpu_rd_ack got=%h exp=%h", {cpu_ack, cpu_rdata, cpu_stall, mem_rd}, {1'b1, 16'h1234, 1'b0, 1'b0});
    end
    cpu_req = 1'b0;
    tick();
    total++;
    if ({cpu_ack, cpu_rdata, owner} !== {1'b0, 16'h1234, 2'd0}) begin
      bad++; $display("FAIL cpu_rd_hold got=%h exp=%h", {cpu_ack, cpu_rdata, owner}, {1'b0, 16'h1234, 2'd0});
    end
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h40; host_wdata = 16'hBEEF;
    tick();
    host_wdata = 16'h5555;
    total++;
    if ({mem_wr, mem_rd, mem_addr, mem_wdata, owner} !== {1'b1, 1'b0, 8'h40, 16'hBEEF, 2'd2}) begin
      bad++; $display("FAIL host_wr_issue got=%h exp=%h", {mem_wr, mem_rd, mem_addr, mem_wdata, owner},
                      {1'b1, 1'b0, 8'h40, 16'hBEEF, 2'd2});
    end
    tick();
    total++;
    if ({host_ack, cpu_ack, host_rdata, mem_wr} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      bad++; $display("FAIL host_wr_ack got=%h exp=%h", {host_ack, cpu_ack, host_rdata, mem_wr}, {1'b1, 1'b0, 16'h0000, 1'b0});
    end
    host_req = 1'b0;
    tick();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    tick();
    total++;
    if ({mem_rd, mem_addr} !== {1'b1, 8'h40}) begin
      bad++; $display("FAIL host_rd_issue got=%h exp=%h", {mem_rd, mem_addr}, {1'b1, 8'h40});
    end
    tick();
    total++;
    if ({host_ack, host_rdata} !== {1'b1, 16'hBEEF}) begin
      bad++; $display("FAIL host_rd_ack got=%h exp=%h", {host_ack, host_rdata}, {1'b1, 16'hBEEF});
    end
    host_req = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_seq [10];
    int ngrant = 0;
    int nack   = 0;
    int last_ack = 0;
    int both_hi = 0;
    exp_seq = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    reset = 1'b0;
    tick();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    for (int c = 0; c < 60 && nack < 10; c++) begin
      tick();
      if (mem_rd && mem_wr) both_hi++;
      if ((mem_rd || mem_wr) && ngrant < 10) begin
        total++;
        if (owner !== exp_seq[ngrant]) begin
          bad++; $display("FAIL fair_grant_%0d got=%0d exp=%0d", ngrant, owner, exp_seq[ngrant]);
        end
        ngrant++;
      end
      if (cpu_ack || host_ack) begin
        if (nack > 0) begin
          total++;
          if (c - last_ack !== 3) begin
            bad++; $display("FAIL fair_ack_spacing got=%0d exp=3", c - last_ack);
          end
        end
        last_ack = c;
        nack++;
      end
    end
    total++;
    if (nack !== 10) begin bad++; $display("FAIL fair_ack_count got=%0d exp=10", nack); end
    total++;
    if (both_hi !== 0) begin bad++; $display("FAIL fair_both_strobes got=%0d exp=0", both_hi); end
    cpu_req = 1'b0; host_req = 1'b0;
    tick();
  endtask

  task automatic test_host_then_cpu();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
    tick();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h12;
    #1;
    total++;
    if ({owner, mem_rd, cpu_stall} !== {2'd2, 1'b1, 1'b1}) begin
      bad++; $display("FAIL hc_issue got=%h exp=%h", {owner, mem_rd, cpu_stall}, {2'd2, 1'b1, 1'b1});
    end
    tick();
    total++;
    if ({host_ack, host_rdata, cpu_ack, cpu_stall} !== {1'b1, 16'hBEEF, 1'b0, 1'b1}) begin
      bad++; $display("FAIL hc_host_ack got=%h exp=%h", {host_ack, host_rdata, cpu_ack, cpu_stall}, {1'b1, 16'hBEEF, 1'b0, 1'b1});
    end
    host_req = 1'b0;
    tick();
    total++;
    if ({owner, mem_rd, cpu_stall} !== {2'd0, 1'b0, 1'b1}) begin
      bad++; $display("FAIL hc_idle got=%h exp=%h", {owner, mem_rd, cpu_stall}, {2'd0, 1'b0, 1'b1});
    end
    tick();
    total++;
    if ({owner, mem_rd, mem_addr, cpu_stall} !== {2'd1, 1'b1, 8'h12, 1'b1}) begin
      bad++; $display("FAIL hc_cpu_issue got=%h exp=%h", {owner, mem_rd, mem_addr, cpu_stall}, {2'd1, 1'b1, 8'h12, 1'b1});
    end
    tick();
    total++;
    if ({cpu_ack, cpu_rdata, cpu_stall} !== {1'b1, 16'h1234, 1'b0}) begin
      bad++; $display("FAIL hc_cpu_ack got=%h exp=%h", {cpu_ack, cpu_rdata, cpu_stall}, {1'b1, 16'h1234, 1'b0});
    end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'hAAAA;
    tick();
    total++;
    if ({mem_wr, mem_addr} !== {1'b1, 8'h05}) begin
      bad++; $display("FAIL mid_issue got=%h exp=%h", {mem_wr, mem_addr}, {1'b1, 8'h05});
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_wr, mem_rd, cpu_ack, owner} !== 5'd0) begin
      bad++; $display("FAIL mid_async_drop got=%h exp=0", {mem_wr, mem_rd, cpu_ack, owner});
    end
    tick();
    total++;
    if ({cpu_ack, mem_wr} !== 2'd0) begin
      bad++; $display("FAIL mid_no_ack got=%h exp=0", {cpu_ack, mem_wr});
    end
    cpu_req = 1'b0;
    reset = 1'b1;
    tick();
    total++;
    if (mem[8'h05] !== 16'h0001) begin
      bad++; $display("FAIL mid_mem_kept got=%h exp=0001", mem[8'h05]);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
    tick();
    total++;
    if ({mem_rd, mem_addr, owner} !== {1'b1, 8'h05, 2'd1}) begin
      bad++; $display("FAIL mid_idle_regrant got=%h exp=%h", {mem_rd, mem_addr, owner}, {1'b1, 8'h05, 2'd1});
    end
    tick();
    total++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h0001}) begin
      bad++; $display("FAIL mid_readback got=%h exp=%h", {cpu_ack, cpu_rdata}, {1'b1, 16'h0001});
    end
    cpu_req = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    pl_en = 1'b0; pl_addr = 8'h0; pl_data = 16'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h0; cpu_wdata = 16'h0;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h0; host_wdata = 16'h0;
    tick();
    test_reset();
    test_cpu_read();
    test_host_write();
    test_fairness();
    test_host_then_cpu();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
